wb_port_arbiter: RTL

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the write-back stage and a 2-entry
// in-order buffer of long-latency aux results, with a starvation-driven stall.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_wregen,
  input  logic [4:0]  wb_wreg1,
  input  logic [63:0] wb_dout,
  input  logic        aux_valid,
  input  logic [4:0]  aux_wreg,
  input  logic [63:0] aux_data,
  output logic        aux_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [63:0] rf_wdata,
  output logic        pipe_stall,
  output logic [1:0]  aux_count
);

  localparam logic [1:0] WAIT_MAX = 2'(STARVE_LIMIT - 1);

  logic [4:0]  fifo_reg  [2];
  logic [63:0] fifo_data [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic [1:0]  wait_cnt;

  logic        non_empty;
  logic        push;
  logic        pop;
  logic        stall_set;
  logic        wait_clear;

  assign non_empty = (count != 2'd0);
  assign aux_ready = (count != 2'd2);
  assign aux_count = count;
  assign push      = aux_valid && aux_ready;

  // While reset is asserted the buffer is treated as already flushed, so only
  // write-back traffic can reach the register file.
  assign pop       = !reset && non_empty && (pipe_stall || !wb_wregen);

  assign stall_set  = non_empty && !pop && (wait_cnt == WAIT_MAX);
  assign wait_clear = pop || stall_set || (!non_empty && !push);

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 64'd0;
    if (pop) begin
      rf_we    = 1'b1;
      rf_waddr = fifo_reg[rd_ptr];
      rf_wdata = fifo_data[rd_ptr];
    end else if (wb_wregen) begin
      rf_we    = 1'b1;
      rf_waddr = wb_wreg1;
      rf_wdata = wb_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_reg[wr_ptr]  <= aux_wreg;
      fifo_data[wr_ptr] <= aux_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
      wait_cnt   <= 2'd0;
      pipe_stall <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (wait_clear)
        wait_cnt <= 2'd0;
      else if (non_empty)
        wait_cnt <= wait_cnt + 2'd1;
      pipe_stall <= stall_set;
    end
  end

endmodule
